// File: rtl/german_data_system.sv
`default_nettype none
// ============================================================================
// Module   : german_data_system
// Purpose  : German cache-coherence protocol with data path. Holds the
//            per-client caches and channels plus the home node, fires at most
//            one guarded rule per clock (selected by io_en_a), and checks the
//            control and data invariants on-line with a sticky violation flag.
// Ports    : clock        - clock
//            reset        - asynchronous, active-low reset
//            io_en_a      - {rule[3:0], client[CW-1:0]} rule select
//            io_data      - store value (Store rule only)
//            io_fired     - registered: previous selected rule had a true guard
//            io_ctrl_ok   - combinational control invariant on current state
//            io_data_ok   - combinational data invariant on current state
//            io_violation - sticky, set once either invariant is seen low
// Revision : 1.0 - initial release
// ============================================================================
module german_data_system #(
   parameter  int NUM_CLIENTS = 3,
   parameter  int DATA_WIDTH  = 2,
   localparam int CW          = ($clog2(NUM_CLIENTS) > 1) ? $clog2(NUM_CLIENTS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [3+CW:0]         io_en_a,
   input  logic [DATA_WIDTH-1:0] io_data,
   output logic                  io_fired,
   output logic                  io_ctrl_ok,
   output logic                  io_data_ok,
   output logic                  io_violation
);

   localparam logic [1:0] c_ci = 2'd0;
   localparam logic [1:0] c_cs = 2'd1;
   localparam logic [1:0] c_ce = 2'd2;

   localparam logic [2:0] c_empty  = 3'd0;
   localparam logic [2:0] c_reqs   = 3'd1;
   localparam logic [2:0] c_reqe   = 3'd2;
   localparam logic [2:0] c_inv    = 3'd3;
   localparam logic [2:0] c_invack = 3'd4;
   localparam logic [2:0] c_gnts   = 3'd5;
   localparam logic [2:0] c_gnte   = 3'd6;

   localparam logic [CW:0] c_num_clients = (CW+1)'(NUM_CLIENTS);

   // Per-client state
   logic [NUM_CLIENTS-1:0][1:0]            r_cache;
   logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] r_cache_data;
   logic [NUM_CLIENTS-1:0][2:0]            r_chan1;
   logic [NUM_CLIENTS-1:0][2:0]            r_chan2;
   logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] r_chan2_data;
   logic [NUM_CLIENTS-1:0][2:0]            r_chan3;
   logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] r_chan3_data;
   logic [NUM_CLIENTS-1:0]                 r_inv_list;
   logic [NUM_CLIENTS-1:0]                 r_sharer_list;

   // Home state
   logic [2:0]            r_cur_cmd;
   logic [CW-1:0]         r_cur_client;
   logic                  r_excl_granted;
   logic [DATA_WIDTH-1:0] r_memory;
   logic [DATA_WIDTH-1:0] r_aux_data;

   logic r_fired;
   logic r_violation;

   logic [3:0]            w_rule;
   logic [CW-1:0]         w_client;
   logic                  w_client_ok;
   logic [CW-1:0]         w_idx;
   logic [1:0]            w_cache;
   logic [2:0]            w_ch1;
   logic [2:0]            w_ch2;
   logic [2:0]            w_ch3;
   logic                  w_guard;
   logic                  w_fire;
   logic                  w_ctrl_ok;
   logic                  w_data_ok;

   assign w_rule      = io_en_a[3+CW:CW];
   assign w_client    = io_en_a[CW-1:0];
   assign w_client_ok = ({1'b0, w_client} < c_num_clients);
   // Out-of-range clients are folded onto 0 so array reads stay in bounds;
   // w_fire is masked by w_client_ok so such selects never change state.
   assign w_idx       = w_client_ok ? w_client : '0;

   assign w_cache = r_cache[w_idx];
   assign w_ch1   = r_chan1[w_idx];
   assign w_ch2   = r_chan2[w_idx];
   assign w_ch3   = r_chan3[w_idx];

   always_comb begin
      w_guard = 1'b0;
      case (w_rule)
         4'd0:  w_guard = (w_ch1 == c_empty) && (w_cache == c_ci);
         4'd1:  w_guard = (w_ch1 == c_empty) && ((w_cache == c_ci) || (w_cache == c_cs));
         4'd2:  w_guard = (r_cur_cmd == c_empty) && (w_ch1 != c_empty);
         4'd3:  w_guard = (w_ch2 == c_empty) && r_inv_list[w_idx] &&
                          ((r_cur_cmd == c_reqe) || ((r_cur_cmd == c_reqs) && r_excl_granted));
         4'd4:  w_guard = (w_ch2 == c_inv) && (w_ch3 == c_empty);
         4'd5:  w_guard = (r_cur_cmd != c_empty) && (w_ch3 == c_invack);
         4'd6:  w_guard = (r_cur_client == w_client) && (r_cur_cmd == c_reqs) &&
                          !r_excl_granted && (w_ch2 == c_empty);
         4'd7:  w_guard = (r_cur_client == w_client) && (r_cur_cmd == c_reqe) &&
                          !r_excl_granted && (w_ch2 == c_empty) && (r_sharer_list == '0);
         4'd8:  w_guard = (w_ch2 == c_gnts);
         4'd9:  w_guard = (w_ch2 == c_gnte);
         4'd10: w_guard = (w_cache == c_ce);
         default: w_guard = 1'b0;
      endcase
   end

   assign w_fire = w_client_ok && w_guard;

   // Control invariant: an exclusive holder excludes every other valid copy.
   always_comb begin
      w_ctrl_ok = 1'b1;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (r_cache[i] == c_ce) begin
            for (int j = 0; j < NUM_CLIENTS; j++) begin
               if ((j != i) && (r_cache[j] != c_ci)) w_ctrl_ok = 1'b0;
            end
         end
      end
   end

   // Data invariant: valid copies and (when no owner exists) memory must
   // hold the last value written by a Store.
   always_comb begin
      w_data_ok = 1'b1;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (((r_cache[i] == c_cs) || (r_cache[i] == c_ce)) && (r_cache_data[i] != r_aux_data))
            w_data_ok = 1'b0;
      end
      if (!r_excl_granted && (r_memory != r_aux_data)) w_data_ok = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cache        <= '0;
         r_cache_data   <= '0;
         r_chan1        <= '0;
         r_chan2        <= '0;
         r_chan2_data   <= '0;
         r_chan3        <= '0;
         r_chan3_data   <= '0;
         r_inv_list     <= '0;
         r_sharer_list  <= '0;
         r_cur_cmd      <= c_empty;
         r_cur_client   <= '0;
         r_excl_granted <= 1'b0;
         r_memory       <= '0;
         r_aux_data     <= '0;
         r_fired        <= 1'b0;
         r_violation    <= 1'b0;
      end else begin
         r_fired <= w_fire;
         if (!w_ctrl_ok || !w_data_ok) r_violation <= 1'b1;
         if (w_fire) begin
            case (w_rule)
               4'd0: r_chan1[w_idx] <= c_reqs;
               4'd1: r_chan1[w_idx] <= c_reqe;
               4'd2: begin
                  r_cur_cmd      <= w_ch1;
                  r_cur_client   <= w_client;
                  r_chan1[w_idx] <= c_empty;
                  r_inv_list     <= r_sharer_list;
               end
               4'd3: begin
                  r_chan2[w_idx]    <= c_inv;
                  r_inv_list[w_idx] <= 1'b0;
               end
               4'd4: begin
                  r_chan2[w_idx] <= c_empty;
                  r_chan3[w_idx] <= c_invack;
                  if (w_cache == c_ce) r_chan3_data[w_idx] <= r_cache_data[w_idx];
                  r_cache[w_idx] <= c_ci;
               end
               4'd5: begin
                  r_chan3[w_idx]       <= c_empty;
                  r_sharer_list[w_idx] <= 1'b0;
                  if (r_excl_granted) begin
                     r_memory       <= r_chan3_data[w_idx];
                     r_excl_granted <= 1'b0;
                  end
               end
               4'd6: begin
                  r_chan2[w_idx]       <= c_gnts;
                  r_chan2_data[w_idx]  <= r_memory;
                  r_sharer_list[w_idx] <= 1'b1;
                  r_cur_cmd            <= c_empty;
               end
               4'd7: begin
                  r_chan2[w_idx]       <= c_gnte;
                  r_chan2_data[w_idx]  <= r_memory;
                  r_sharer_list[w_idx] <= 1'b1;
                  r_excl_granted       <= 1'b1;
                  r_cur_cmd            <= c_empty;
               end
               4'd8: begin
                  r_cache[w_idx]      <= c_cs;
                  r_cache_data[w_idx] <= r_chan2_data[w_idx];
                  r_chan2[w_idx]      <= c_empty;
               end
               4'd9: begin
                  r_cache[w_idx]      <= c_ce;
                  r_cache_data[w_idx] <= r_chan2_data[w_idx];
                  r_chan2[w_idx]      <= c_empty;
               end
               4'd10: begin
                  r_cache_data[w_idx] <= io_data;
                  r_aux_data          <= io_data;
               end
               default: ;
            endcase
         end
      end
   end

   assign io_fired     = r_fired;
   assign io_ctrl_ok   = w_ctrl_ok;
   assign io_data_ok   = w_data_ok;
   assign io_violation = r_violation;

endmodule
`default_nettype wire

// File: tb/tb_german_data_system.sv
`default_nettype none
// ============================================================================
// Module   : tb_german_data_system
// Purpose  : Self-checking bench for german_data_system (3 clients, 2-bit
//            data). Directed protocol scenarios followed by random rule
//            selection, all checked against a behavioural protocol model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_german_data_system;

   localparam int NC = 3;

   // Model encodings
   localparam int CI = 0, CS = 1, CE = 2;
   localparam int EMPTY = 0, REQS = 1, REQE = 2, INV = 3, INVACK = 4, GNTS = 5, GNTE = 6;

   logic       clock;
   logic       reset;
   logic [5:0] io_en_a;
   logic [1:0] io_data;
   logic       io_fired;
   logic       io_ctrl_ok;
   logic       io_data_ok;
   logic       io_violation;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state
   int m_cache[NC], m_cdata[NC], m_ch1[NC], m_ch2[NC], m_ch2d[NC], m_ch3[NC], m_ch3d[NC];
   bit m_inv[NC], m_sh[NC];
   int m_cmd, m_cli, m_mem, m_aux;
   bit m_excl, m_viol;

   german_data_system #(.NUM_CLIENTS(3), .DATA_WIDTH(2)) dut (
      .clock       (clock),
      .reset       (reset),
      .io_en_a     (io_en_a),
      .io_data     (io_data),
      .io_fired    (io_fired),
      .io_ctrl_ok  (io_ctrl_ok),
      .io_data_ok  (io_data_ok),
      .io_violation(io_violation)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_cache[i] = CI; m_cdata[i] = 0; m_ch1[i] = EMPTY; m_ch2[i] = EMPTY;
         m_ch2d[i] = 0; m_ch3[i] = EMPTY; m_ch3d[i] = 0; m_inv[i] = 0; m_sh[i] = 0;
      end
      m_cmd = EMPTY; m_cli = 0; m_mem = 0; m_aux = 0; m_excl = 0; m_viol = 0;
   endtask

   function automatic bit model_ctrl_ok();
      int n_valid = 0;
      int n_excl  = 0;
      for (int i = 0; i < NC; i++) begin
         if (m_cache[i] != CI) n_valid++;
         if (m_cache[i] == CE) n_excl++;
      end
      return !(n_excl > 0 && n_valid > 1);
   endfunction

   function automatic bit model_data_ok();
      for (int i = 0; i < NC; i++)
         if ((m_cache[i] == CS || m_cache[i] == CE) && m_cdata[i] != m_aux) return 0;
      if (!m_excl && m_mem != m_aux) return 0;
      return 1;
   endfunction

   function automatic bit no_sharers();
      for (int i = 0; i < NC; i++) if (m_sh[i]) return 0;
      return 1;
   endfunction

   // Applies one rule to the model; f reports whether its guard held.
   task automatic model_step(input int r, input int c, input int d, output bit f);
      f = 0;
      if (c < NC) begin
         case (r)
            0: if (m_ch1[c] == EMPTY && m_cache[c] == CI) begin f = 1; m_ch1[c] = REQS; end
            1: if (m_ch1[c] == EMPTY && m_cache[c] != CE) begin f = 1; m_ch1[c] = REQE; end
            2: if (m_cmd == EMPTY && m_ch1[c] != EMPTY) begin
                  f = 1; m_cmd = m_ch1[c]; m_cli = c; m_ch1[c] = EMPTY;
                  for (int j = 0; j < NC; j++) m_inv[j] = m_sh[j];
               end
            3: if (m_ch2[c] == EMPTY && m_inv[c] && (m_cmd == REQE || (m_cmd == REQS && m_excl))) begin
                  f = 1; m_ch2[c] = INV; m_inv[c] = 0;
               end
            4: if (m_ch2[c] == INV && m_ch3[c] == EMPTY) begin
                  f = 1; m_ch2[c] = EMPTY; m_ch3[c] = INVACK;
                  if (m_cache[c] == CE) m_ch3d[c] = m_cdata[c];
                  m_cache[c] = CI;
               end
            5: if (m_cmd != EMPTY && m_ch3[c] == INVACK) begin
                  f = 1; m_ch3[c] = EMPTY; m_sh[c] = 0;
                  if (m_excl) begin m_mem = m_ch3d[c]; m_excl = 0; end
               end
            6: if (m_cli == c && m_cmd == REQS && !m_excl && m_ch2[c] == EMPTY) begin
                  f = 1; m_ch2[c] = GNTS; m_ch2d[c] = m_mem; m_sh[c] = 1; m_cmd = EMPTY;
               end
            7: if (m_cli == c && m_cmd == REQE && !m_excl && m_ch2[c] == EMPTY && no_sharers()) begin
                  f = 1; m_ch2[c] = GNTE; m_ch2d[c] = m_mem; m_sh[c] = 1; m_excl = 1; m_cmd = EMPTY;
               end
            8: if (m_ch2[c] == GNTS) begin f = 1; m_cache[c] = CS; m_cdata[c] = m_ch2d[c]; m_ch2[c] = EMPTY; end
            9: if (m_ch2[c] == GNTE) begin f = 1; m_cache[c] = CE; m_cdata[c] = m_ch2d[c]; m_ch2[c] = EMPTY; end
            10: if (m_cache[c] == CE) begin f = 1; m_cdata[c] = d; m_aux = d; end
            default: f = 0;
         endcase
      end
   endtask

   task automatic check_state(input string tag);
      logic [5:0] e_cache, e_cd, e_c2d, e_c3d;
      logic [8:0] e_c1, e_c2, e_c3;
      logic [2:0] e_inv, e_sh;
      for (int i = 0; i < NC; i++) begin
         e_cache[2*i +: 2] = 2'(m_cache[i]);
         e_cd[2*i +: 2]    = 2'(m_cdata[i]);
         e_c2d[2*i +: 2]   = 2'(m_ch2d[i]);
         e_c3d[2*i +: 2]   = 2'(m_ch3d[i]);
         e_c1[3*i +: 3]    = 3'(m_ch1[i]);
         e_c2[3*i +: 3]    = 3'(m_ch2[i]);
         e_c3[3*i +: 3]    = 3'(m_ch3[i]);
         e_inv[i]          = m_inv[i];
         e_sh[i]           = m_sh[i];
      end
      chk({tag, ".cache"},  32'(dut.r_cache),        32'(e_cache));
      chk({tag, ".cdata"},  32'(dut.r_cache_data),   32'(e_cd));
      chk({tag, ".chan1"},  32'(dut.r_chan1),        32'(e_c1));
      chk({tag, ".chan2"},  32'(dut.r_chan2),        32'(e_c2));
      chk({tag, ".chan2d"}, 32'(dut.r_chan2_data),   32'(e_c2d));
      chk({tag, ".chan3"},  32'(dut.r_chan3),        32'(e_c3));
      chk({tag, ".chan3d"}, 32'(dut.r_chan3_data),   32'(e_c3d));
      chk({tag, ".inv"},    32'(dut.r_inv_list),     32'(e_inv));
      chk({tag, ".sharer"}, 32'(dut.r_sharer_list),  32'(e_sh));
      chk({tag, ".cmd"},    32'(dut.r_cur_cmd),      32'(m_cmd));
      chk({tag, ".excl"},   32'(dut.r_excl_granted), 32'(m_excl));
      chk({tag, ".mem"},    32'(dut.r_memory),       32'(m_mem));
      chk({tag, ".aux"},    32'(dut.r_aux_data),     32'(m_aux));
      if (m_cmd != EMPTY) chk({tag, ".client"}, 32'(dut.r_cur_client), 32'(m_cli));
   endtask

   // One clocked rule application, checked against the model afterwards.
   task automatic step(input string tag, input int r, input int c, input int d);
      bit f;
      io_en_a = {4'(r), 2'(c)};
      io_data = 2'(d);
      if (!model_ctrl_ok() || !model_data_ok()) m_viol = 1;
      model_step(r, c, d, f);
      @(posedge clock);
      #1;
      chk({tag, ".fired"},   32'(io_fired),     32'(f));
      chk({tag, ".viol"},    32'(io_violation), 32'(m_viol));
      chk({tag, ".ctrl_ok"}, 32'(io_ctrl_ok),   32'(model_ctrl_ok()));
      chk({tag, ".data_ok"}, 32'(io_data_ok),   32'(model_data_ok()));
      check_state(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".fired"},   32'(io_fired),     32'd0);
      chk({tag, ".viol"},    32'(io_violation), 32'd0);
      chk({tag, ".ctrl_ok"}, 32'(io_ctrl_ok),   32'd1);
      chk({tag, ".data_ok"}, 32'(io_data_ok),   32'd1);
      chk({tag, ".cmd"},     32'(dut.r_cur_cmd), 32'd0);
      chk({tag, ".cache"},   32'(dut.r_cache),   32'd0);
   endtask

   task automatic pulse_reset(input string tag);
      reset   = 1'b0;
      io_en_a = 6'h3C;
      #1;
      check_reset_outputs(tag);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      reset   = 1'b0;
      io_en_a = 6'h3C;
      io_data = 2'd0;
      model_reset();
      #12;
      check_reset_outputs("rst0");
      check_state("rst0");
      @(negedge clock);
      reset = 1'b1;

      // First request from client 0, then two refused repeats
      step("req0_a", 0, 0, 0);
      chk("req0_a.chan1_0", 32'(dut.r_chan1[0]), 32'd1);
      step("req0_b", 0, 0, 0);
      step("req0_c", 0, 0, 0);

      // Client 1 takes exclusive ownership and stores 3
      step("c1_reqe", 1, 1, 0);
      step("c1_recv", 2, 1, 0);
      step("c1_gnte", 7, 1, 0);
      step("c1_rgnte", 9, 1, 0);
      step("c1_store", 10, 1, 3);
      chk("c1_store.cache1", 32'(dut.r_cache[1]),      32'd2);
      chk("c1_store.cdata1", 32'(dut.r_cache_data[1]), 32'd3);
      chk("c1_store.aux",    32'(dut.r_aux_data),      32'd3);
      chk("c1_store.mem",    32'(dut.r_memory),        32'd0);
      chk("c1_store.dok",    32'(io_data_ok),          32'd1);

      // Client 0 shared request forces recall of client 1's dirty line
      step("c0_reqs", 0, 0, 0);
      step("c0_recv", 2, 0, 0);
      step("inv1", 3, 1, 0);
      step("invack1", 4, 1, 0);
      step("rinvack1", 5, 1, 0);
      step("gnts0", 6, 0, 0);
      step("rgnts0", 8, 0, 0);
      chk("recall.mem",    32'(dut.r_memory),        32'd3);
      chk("recall.cache0", 32'(dut.r_cache[0]),      32'd1);
      chk("recall.cdata0", 32'(dut.r_cache_data[0]), 32'd3);
      chk("recall.excl",   32'(dut.r_excl_granted),  32'd0);
      chk("recall.cache1", 32'(dut.r_cache[1]),      32'd0);

      // Illegal selects: reserved rule and out-of-range client
      step("rule12", 12, 0, 0);
      step("client3", 1, 3, 0);
      step("store_c3", 10, 3, 1);

      // Random rule selection against the model
      for (int k = 0; k < 400; k++) begin
         step("rand", int'($urandom_range(0, 11)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Set up a pending exclusive request on client 2
      pulse_reset("rst1");
      step("c2_reqe", 1, 2, 0);
      step("c2_recv", 2, 2, 0);
      chk("pend.cmd", 32'(dut.r_cur_cmd), 32'd2);

      // Corrupted state: client 0 exclusive while client 2 shares
      force dut.r_cache = 6'b01_00_10;
      #1;
      chk("corrupt.ctrl_ok",  32'(io_ctrl_ok),   32'd0);
      chk("corrupt.viol_pre", 32'(io_violation), 32'd0);
      io_en_a = 6'h3C;
      @(posedge clock);
      #1;
      chk("corrupt.viol_set", 32'(io_violation), 32'd1);
      release dut.r_cache;
      for (int k = 0; k < 3; k++) begin
         @(posedge clock);
         #1;
         chk("corrupt.viol_hold", 32'(io_violation), 32'd1);
      end
      chk("corrupt.cmd_pend", 32'(dut.r_cur_cmd), 32'd2);

      // Mid-cycle reset with the request still pending
      #2;
      pulse_reset("rst_async");
      step("post_rst", 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
